// File: rtl/load_sched.sv
// Round-robin scheduler that loads a seed into a shared 3-bit register,
// lets it free-run for run_len clocks and captures the resulting state.
//
// Ports:
//   clk, areset         clock, asynchronous active-high reset
//   req0/val0, req1/val1  load requests and their seed values
//   run_len             free-run clock count, sampled at the end of LOAD
//   q                   current state of the shared register
//   r, L                seed value and load strobe to the shared register
//   gnt0, gnt1          one-cycle grant pulses (during LOAD)
//   busy, done, result  status, completion pulse, captured register state
module load_sched #(
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             req0,
    input  logic [2:0]       val0,
    input  logic             req1,
    input  logic [2:0]       val1,
    input  logic [RUN_W-1:0] run_len,
    input  logic [2:0]       q,
    output logic [2:0]       r,
    output logic             L,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [2:0]       result
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [RUN_W-1:0] cnt;
    logic [2:0]       seed;
    logic             last;
    logic             pick;

    // On a tie the requester that did not win last time is chosen.
    // last doubles as the owner of the job in progress.
    always_comb begin
        pick = (req0 && req1) ? ~last : req1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt  = state;
        L    = 1'b0;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) begin
                    nxt = LOAD;
                end
            end
            LOAD: begin
                L    = 1'b1;
                gnt0 = ~last;
                gnt1 = last;
                nxt  = RUN;
            end
            RUN: begin
                if (cnt == '0) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            seed   <= 3'b000;
            last   <= 1'b1;
            cnt    <= '0;
            result <= 3'b000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        seed <= pick ? val1 : val0;
                        last <= pick;
                    end
                end
                LOAD: begin
                    cnt <= run_len;
                end
                RUN: begin
                    // Zero count ends the run and captures the register.
                    if (cnt != '0) begin
                        cnt <= cnt - RUN_W'(1);
                    end else begin
                        result <= q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign r = seed;

endmodule

// File: tb/tb_load_sched.sv
// Testbench for load_sched: scenario tasks plus randomized jobs checked
// against a simple arithmetic model of the shared register (adds 3/clock).
module tb_load_sched;

    logic       clk = 1'b0;
    logic       areset;
    logic       req0;
    logic [2:0] val0;
    logic       req1;
    logic [2:0] val1;
    logic [3:0] run_len;
    logic [2:0] q;
    logic [2:0] r;
    logic       L;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic [2:0] result;

    int         checks = 0;
    int         errors = 0;
    bit         exp_last = 1'b1;
    logic [2:0] exp_res = 3'b000;
    logic [2:0] qreg = 3'b000;

    load_sched #(.RUN_W(4)) dut (
        .clk(clk),
        .areset(areset),
        .req0(req0),
        .val0(val0),
        .req1(req1),
        .val1(val1),
        .run_len(run_len),
        .q(q),
        .r(r),
        .L(L),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Shared register: loads r on L, otherwise counts up by 3.
    always @(posedge clk) begin
        if (L) qreg <= r;
        else qreg <= qreg + 3'd3;
    end
    assign q = qreg;

    // Called at the negedge of the expected LOAD cycle; follows the job
    // through RUN, DONE and the IDLE cycle that follows.
    task automatic check_job(input string tag, input bit w,
                             input logic [2:0] seed, input int rl,
                             input logic [1:0] clr, input bit late);
        logic [10:0] got;
        logic [10:0] exp;
        got = {L, gnt0, gnt1, busy, done, r, result};
        exp = {1'b1, !w, w, 1'b1, 1'b0, seed, exp_res};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_load got %b want %b", tag, got, exp);
        end
        if (clr[0]) req0 = 1'b0;
        if (clr[1]) req1 = 1'b0;
        for (int i = 0; i <= rl; i++) begin
            @(negedge clk);
            if (i == 0) begin
                run_len = 4'($urandom);
                val0 = 3'($urandom);
                val1 = 3'($urandom);
                if (late) req1 = 1'b1;
            end
            got = {L, gnt0, gnt1, busy, done, r, result};
            exp = {5'b00010, seed, exp_res};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_run%0d got %b want %b", tag, i, got, exp);
            end
        end
        @(negedge clk);
        exp_res = 3'(int'(seed) + 3 * rl);
        got = {L, gnt0, gnt1, busy, done, r, result};
        exp = {5'b00011, seed, exp_res};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_done got %b want %b", tag, got, exp);
        end
        @(negedge clk);
        got = {L, gnt0, gnt1, busy, done, r, result};
        exp = {5'b00000, seed, exp_res};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_idle got %b want %b", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [10:0] got;
        areset = 1'b1;
        req0 = 1'b1;
        req1 = 1'b0;
        val0 = 3'b101;
        val1 = 3'b000;
        run_len = 4'd0;
        #1;
        got = {L, gnt0, gnt1, busy, done, r, result};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_async got %b want 0", got);
        end
        repeat (2) begin
            @(negedge clk);
            got = {L, gnt0, gnt1, busy, done, r, result};
            checks++;
            if (got !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold got %b want 0", got);
            end
        end
        areset = 1'b0;
        exp_last = 1'b0;
        @(negedge clk);
        check_job("single", 1'b0, 3'b101, 0, 2'b01, 1'b0);
    endtask

    task automatic test_run_count();
        req1 = 1'b1;
        val1 = 3'b001;
        run_len = 4'd4;
        exp_last = 1'b1;
        @(negedge clk);
        check_job("count", 1'b1, 3'b001, 4, 2'b10, 1'b0);
    endtask

    task automatic test_late();
        logic [2:0] s;
        s = 3'($urandom);
        req0 = 1'b1;
        val0 = s;
        run_len = 4'd3;
        exp_last = 1'b0;
        @(negedge clk);
        check_job("late0", 1'b0, s, 3, 2'b01, 1'b1);
        s = 3'($urandom);
        val1 = s;
        run_len = 4'd0;
        exp_last = 1'b1;
        @(negedge clk);
        check_job("late1", 1'b1, s, 0, 2'b10, 1'b0);
    endtask

    task automatic test_abort();
        logic [10:0] got;
        logic [10:0] exp;
        logic [2:0]  s;
        s = 3'($urandom);
        req0 = 1'b1;
        val0 = s;
        run_len = 4'd8;
        @(negedge clk);
        got = {L, gnt0, gnt1, busy, done, r, result};
        exp = {5'b11010, s, exp_res};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL abort_load got %b want %b", got, exp);
        end
        repeat (3) @(negedge clk);
        areset = 1'b1;
        exp_last = 1'b1;
        exp_res = 3'b000;
        #1;
        got = {L, gnt0, gnt1, busy, done, r, result};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL abort_now got %b want 0", got);
        end
        repeat (2) begin
            @(negedge clk);
            got = {L, gnt0, gnt1, busy, done, r, result};
            checks++;
            if (got !== 11'd0) begin
                errors++;
                $display("FAIL abort_hold got %b want 0", got);
            end
        end
        s = 3'($urandom);
        val0 = s;
        run_len = 4'd2;
        areset = 1'b0;
        exp_last = 1'b0;
        @(negedge clk);
        check_job("reload", 1'b0, s, 2, 2'b01, 1'b0);
    endtask

    task automatic test_tie();
        areset = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        val0 = 3'b011;
        val1 = 3'b110;
        run_len = 4'd1;
        exp_last = 1'b1;
        exp_res = 3'b000;
        @(negedge clk);
        areset = 1'b0;
        exp_last = 1'b0;
        @(negedge clk);
        check_job("tie0", 1'b0, 3'b011, 1, 2'b00, 1'b0);
        val0 = 3'b011;
        val1 = 3'b110;
        run_len = 4'd1;
        exp_last = 1'b1;
        @(negedge clk);
        check_job("tie1", 1'b1, 3'b110, 1, 2'b00, 1'b0);
        val0 = 3'b011;
        val1 = 3'b110;
        run_len = 4'd1;
        exp_last = 1'b0;
        @(negedge clk);
        check_job("tie2", 1'b0, 3'b011, 1, 2'b11, 1'b0);
    endtask

    task automatic test_random();
        bit         a;
        bit         b;
        bit         w;
        int         rl;
        logic [2:0] s;
        for (int k = 0; k < 40; k++) begin
            a = req0 | 1'($urandom);
            b = req1 | 1'($urandom);
            if (!a && !b) a = 1'b1;
            req0 = a;
            req1 = b;
            val0 = 3'($urandom);
            val1 = 3'($urandom);
            rl = int'($urandom_range(0, 15));
            run_len = 4'(rl);
            w = (a && b) ? !exp_last : b;
            exp_last = w;
            s = w ? val1 : val0;
            @(negedge clk);
            check_job("rand", w, s, rl, w ? 2'b10 : 2'b01, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_late();
        test_abort();
        test_tie();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
